// File: rtl/usadd_uni_dec.sv
// Unipolar stochastic-to-binary decoder: counts ones over a 2^BITWIDTH-cycle window
// and holds the count under valid/ready. Optional macro USADD_DEC_RESCALE_EN rescales by BINPUT.
module usadd_uni_dec #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned BINPUT   = 2
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iBit,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH:0]   oCnt
);

  localparam int unsigned CNT_W  = BITWIDTH + 1;
  localparam int unsigned PROD_W = CNT_W + $clog2(BINPUT);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(1) << BITWIDTH;
  localparam logic [BITWIDTH-1:0] WIN_LAST = '1;

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] win_q, win_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                valid_d, busy_d;
  logic [CNT_W-1:0]    final_c;
  logic [PROD_W-1:0]   scaled_c;
  logic [CNT_W-1:0]    cnt_sat_c;

  // Final count includes the bit sampled on the last window edge.
  assign final_c = acc_q + CNT_W'(iBit);

`ifdef USADD_DEC_RESCALE_EN
  assign scaled_c = PROD_W'(final_c) * PROD_W'(BINPUT);
`else
  assign scaled_c = PROD_W'(final_c);
`endif

  assign cnt_sat_c = (scaled_c > PROD_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(scaled_c);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      win_q   <= '0;
      acc_q   <= '0;
      oCnt    <= '0;
      oValid  <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      oCnt    <= cnt_d;
      oValid  <= valid_d;
      oBusy   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    acc_d   = acc_q;
    cnt_d   = oCnt;
    valid_d = oValid;
    busy_d  = oBusy;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = COUNT;
          win_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      COUNT: begin
        // Window counter wraps to 0 on the last sample by design.
        acc_d = final_c;
        win_d = win_q + BITWIDTH'(1);
        if (win_q == WIN_LAST) begin
          cnt_d   = cnt_sat_c;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (iReady) begin
          valid_d = 1'b0;
          if (iStart) begin
            state_d = COUNT;
            win_d   = '0;
            acc_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usadd_uni_dec.sv
// Bench for usadd_uni_dec: integer window model checked every cycle plus directed literal checks.
module tb_usadd_uni_dec;

  localparam int BW     = 8;
  localparam int BINPUT = 2;
  localparam int WIN    = 1 << BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, bit_in, ready;
  logic          busy, valid;
  logic [BW:0]   cnt;

  int n_checks = 0;
  int n_fail   = 0;

  usadd_uni_dec #(.BITWIDTH(BW), .BINPUT(BINPUT)) dut (
    .iClk(clk), .iRstN(rst_n), .iStart(start), .iBit(bit_in), .iReady(ready),
    .oBusy(busy), .oValid(valid), .oCnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int scale(input int s);
`ifdef USADD_DEC_RESCALE_EN
    return (s * BINPUT > WIN) ? WIN : s * BINPUT;
`else
    return s;
`endif
  endfunction

  // Model: samples remaining in the current window and running sum of ones.
  int m_left, m_sum, m_cnt;
  bit m_valid, m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_sum = 0; m_cnt = 0; m_valid = 0; m_busy = 0;
    end else if (m_left > 0) begin
      m_sum  += int'(bit_in);
      m_left -= 1;
      if (m_left == 0) begin
        m_cnt = scale(m_sum); m_valid = 1; m_busy = 0;
      end
    end else if (m_valid) begin
      if (ready) begin
        m_valid = 0;
        if (start) begin m_left = WIN; m_sum = 0; m_busy = 1; end
      end
    end else if (start) begin
      m_left = WIN; m_sum = 0; m_busy = 1;
    end
  end

  always @(negedge clk) begin
    check("model_busy",  32'(busy),  32'(m_busy));
    check("model_valid", 32'(valid), 32'(m_valid));
    check("model_cnt",   32'(cnt),   32'(m_cnt));
  end

  // mode 0: first n samples are 1; mode 1: alternating 1,0
  function automatic logic bit_at(input int mode, input int n, input int i);
    if (mode == 1) return (i % 2 == 0);
    return (i < n);
  endfunction

  task automatic feed(input int mode, input int n, input int first);
    for (int i = first; i < WIN; i++) begin
      @(negedge clk);
      start  = 1'b0;
      bit_in = bit_at(mode, n, i);
    end
    @(negedge clk);
  endtask

  task automatic expect_result(input string name, input int exp);
    check({name, "_valid"}, 32'(valid), 32'd1);
    check({name, "_busy"},  32'(busy),  32'd0);
    check({name, "_cnt"},   32'(cnt),   32'(exp));
  endtask

  task automatic run_window(input int mode, input int n, input string name, input int exp);
    @(negedge clk);
    start = 1'b1;
    feed(mode, n, 0);
    expect_result(name, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_cnt",   32'(cnt),   32'd0);
    rst_n = 1'b1;

    // 1: all ones, consumer always ready
    ready = 1'b1;
    run_window(0, WIN, "t1", 256);
    @(negedge clk);
    check("t1_valid_drop", 32'(valid), 32'd0);
    check("t1_idle_busy",  32'(busy),  32'd0);
    check("t1_cnt_kept",   32'(cnt),   32'd256);

    // 2: alternating and all zero
    run_window(1, 0, "t2a", 128);
    @(negedge clk);
    run_window(0, 0, "t2b", 0);
    @(negedge clk);

    // 3: hold with ready low; start during hold ignored
    ready = 1'b0;
    run_window(0, 77, "t3", 77);
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);
      @(negedge clk);
      check("t3_hold_valid", 32'(valid), 32'd1);
      check("t3_hold_cnt",   32'(cnt),   32'd77);
    end
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("t3_release_valid", 32'(valid), 32'd0);
    ready = 1'b0;

    // 4: back-to-back window via handshake + start on same edge
    run_window(1, 0, "t4a", 128);
    ready = 1'b1; start = 1'b1;
    @(negedge clk);
    check("t4_b2b_valid", 32'(valid), 32'd0);
    check("t4_b2b_busy",  32'(busy),  32'd1);
    start = 1'b0; ready = 1'b0;
    bit_in = bit_at(0, 37, 0);
    feed(0, 37, 1);
    expect_result("t4b", 37);
    ready = 1'b1;
    @(negedge clk);

    // 5: reset mid-window discards everything
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0; bit_in = 1'b1;
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_busy",  32'(busy),  32'd0);
    check("t5_rst_valid", 32'(valid), 32'd0);
    check("t5_rst_cnt",   32'(cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_window(0, 64, "t5", 64);
    @(negedge clk);

    // 6: rescale behaviour depends on build macro
`ifdef USADD_DEC_RESCALE_EN
    run_window(0, 100, "t6a", 200);
    @(negedge clk);
    run_window(0, 192, "t6b", 256);
`else
    run_window(0, 100, "t6a", 100);
    @(negedge clk);
    run_window(0, 192, "t6b", 192);
`endif
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
